// File: rtl/switch_debouncer.sv
// Two-channel switch conditioner: 2-flop synchroniser plus a counting debounce FSM per channel.
// Produces registered clean levels and a one-cycle pulse on each debounced rising edge.
module switch_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic SW_X,
    input  logic SW_Y,
    output logic X,
    output logic Y,
    output logic X_RISE,
    output logic Y_RISE
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLo     = 2'd0,
        StWaitHi = 2'd1,
        StHi     = 2'd2,
        StWaitLo = 2'd3
    } state_e;

    logic [1:0] sw_raw;
    logic [1:0] level;
    logic [1:0] rise;

    assign sw_raw = {SW_Y, SW_X};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             s1_q;
        logic             s2_q;
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_q;
        logic             out_d;
        logic             rise_q;
        logic             rise_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= StLo;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                s1_q    <= sw_raw[g];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
            end
        end

        // The count holds the number of consecutive contrary samples seen so far.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            out_d   = out_q;
            rise_d  = 1'b0;
            case (state_q)
                StLo: begin
                    if (s2_q) begin
                        state_d = StWaitHi;
                        cnt_d   = CntOne;
                    end
                end
                StWaitHi: begin
                    if (!s2_q) begin
                        state_d = StLo;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHi;
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StHi: begin
                    if (!s2_q) begin
                        state_d = StWaitLo;
                        cnt_d   = CntOne;
                    end
                end
                StWaitLo: begin
                    if (s2_q) begin
                        state_d = StHi;
                    end else if (cnt_q == CntLast) begin
                        state_d = StLo;
                        out_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StLo;
                end
            endcase
        end

        assign level[g] = out_q;
        assign rise[g]  = rise_q;
    end

    assign X      = level[0];
    assign Y      = level[1];
    assign X_RISE = rise[0];
    assign Y_RISE = rise[1];

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed per-edge vector table, then random bouncy
// stimulus checked against a run-length reference model.
module tb_switch_debouncer;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    logic sw_x;
    logic sw_y;
    logic x;
    logic y;
    logic xr;
    logic yr;

    switch_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .SW_X   (sw_x),
        .SW_Y   (sw_y),
        .X      (x),
        .Y      (y),
        .X_RISE (xr),
        .Y_RISE (yr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       sx;
        logic       sy;
        logic [3:0] exp;   // {X, Y, X_RISE, Y_RISE} after the edge
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: each channel flips once N consecutive observed samples
    // disagree with its level; observations lag the pin by two edges.
    logic hx[$];
    logic hy[$];
    logic [1:0] m_out;
    logic [1:0] m_rise;
    int         m_run[2];

    function automatic void add_vec(input logic r, input logic sx, input logic sy,
                                    input logic [3:0] exp, input int n);
        vec_t v;
        v.r   = r;
        v.sx  = sx;
        v.sy  = sy;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic void model_chan(input int c, input logic obs);
        m_rise[c] = 1'b0;
        if (obs != m_out[c]) begin
            m_run[c]++;
            if (m_run[c] == N) begin
                m_out[c]  = obs;
                m_rise[c] = obs;
                m_run[c]  = 0;
            end
        end else begin
            m_run[c] = 0;
        end
    endfunction

    function automatic void model_step(input logic r, input logic sx, input logic sy);
        if (r) begin
            hx       = '{1'b0, 1'b0};
            hy       = '{1'b0, 1'b0};
            m_out    = 2'b00;
            m_rise   = 2'b00;
            m_run[0] = 0;
            m_run[1] = 0;
        end else begin
            model_chan(0, hx.pop_front());
            model_chan(1, hy.pop_front());
            hx.push_back(sx);
            hy.push_back(sy);
        end
    endfunction

    task automatic step(input logic r, input logic sx, input logic sy);
        rst  = r;
        sw_x = sx;
        sw_y = sy;
        @(posedge clk);
        model_step(r, sx, sy);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got {X,Y,XR,YR}=%b want %b", name, idx, act, exp);
        end
    endtask

    initial begin
        logic tgt_x;
        logic tgt_y;
        logic sx;
        logic sy;
        logic r;

        // Reset held with both switches on, then release: both rise together.
        add_vec(1, 1, 1, 4'b0000, 3);   // edges 0-2
        add_vec(0, 1, 1, 4'b0000, 5);   // 3-7
        add_vec(0, 1, 1, 4'b1111, 1);   // 8
        add_vec(0, 1, 1, 4'b1100, 1);   // 9
        add_vec(0, 0, 0, 4'b1100, 5);   // 10-14 release, no fall pulse
        add_vec(0, 0, 0, 4'b0000, 1);   // 15
        // Clean press on X only.
        add_vec(0, 1, 0, 4'b0000, 5);   // 16-20
        add_vec(0, 1, 0, 4'b1010, 1);   // 21
        add_vec(0, 1, 0, 4'b1000, 2);   // 22-23
        add_vec(0, 0, 0, 4'b1000, 5);   // 24-28
        add_vec(0, 0, 0, 4'b0000, 1);   // 29
        // Bounce 1,0,1,0 then held: rise 5 edges after edge 34.
        add_vec(0, 1, 0, 4'b0000, 1);   // 30
        add_vec(0, 0, 0, 4'b0000, 1);   // 31
        add_vec(0, 1, 0, 4'b0000, 1);   // 32
        add_vec(0, 0, 0, 4'b0000, 1);   // 33
        add_vec(0, 1, 0, 4'b0000, 5);   // 34-38
        add_vec(0, 1, 0, 4'b1010, 1);   // 39
        add_vec(0, 1, 0, 4'b1000, 2);   // 40-41
        // Release with a one-cycle glitch at edge 44: falls after edge 50.
        add_vec(0, 0, 0, 4'b1000, 2);   // 42-43
        add_vec(0, 1, 0, 4'b1000, 1);   // 44
        add_vec(0, 0, 0, 4'b1000, 5);   // 45-49
        add_vec(0, 0, 0, 4'b0000, 1);   // 50
        // Reset while X is mid-qualification, then re-qualify from scratch.
        add_vec(0, 1, 0, 4'b0000, 3);   // 51-53
        add_vec(1, 1, 0, 4'b0000, 1);   // 54
        add_vec(0, 1, 0, 4'b0000, 5);   // 55-59
        add_vec(0, 1, 0, 4'b1010, 1);   // 60
        add_vec(0, 1, 0, 4'b1000, 1);   // 61
        // Reset while high clears level and never pulses.
        add_vec(1, 1, 1, 4'b0000, 1);   // 62
        add_vec(0, 0, 0, 4'b0000, 2);   // 63-64

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].sx, vecs[i].sy);
            check("vec", i, {x, y, xr, yr}, vecs[i].exp);
        end

        tgt_x = 1'b0;
        tgt_y = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11) == 0) tgt_x = ~tgt_x;
            if ($urandom_range(11) == 0) tgt_y = ~tgt_y;
            sx = tgt_x ^ ($urandom_range(4) == 0);
            sy = tgt_y ^ ($urandom_range(4) == 0);
            r  = ($urandom_range(299) == 0);
            step(r, sx, sy);
            check("rand", i, {x, y, xr, yr}, {m_out[0], m_out[1], m_rise[0], m_rise[1]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
